// File: rtl/key_expansion.sv
// AES-128 key schedule: expands a 128-bit cipher key into 11 round keys,
// one round key per clock, and presents them all on a single 1408-bit bus.
// Round key r sits in out[1407-128r -: 128]; done marks a complete schedule.
//
// Handshake: enable is a level request sampled only in IDLE and DONE. A high
// level in IDLE starts an expansion. enable and key are ignored while RUN is
// active. done stays high in DONE until enable is dropped, so a new expansion
// requires enable low for at least one cycle first.
module key_expansion (
    input  logic            CLK,
    input  logic            RST,
    input  logic [0:127]    key,
    input  logic            enable,
    output logic [1407:0]   out,
    output logic            done,
    output logic [1:0]      fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic [127:0]   last_rk;
    logic [127:0]   key_flat;
    logic [127:0]   rk1;
    logic [127:0]   rk_next;

    // AES forward S-box, entry 0 in the leftmost byte.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    // SubWord(RotWord(w)): rotate bytes left by one, then substitute each.
    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Four words chained combinationally: next round key from the previous one.
    function automatic logic [127:0] next_round_key(input logic [127:0] rk,
                                                    input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h000000};
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // key[0] is the MSB, so a plain copy puts w0 in the top word.
    assign key_flat  = key;
    assign fsm_state = state;

    // Round key 1 straight from the input key, and the next key in the chain.
    always_comb begin
        rk1     = next_round_key(key_flat, 8'h01);
        rk_next = next_round_key(last_rk, rcon_of(cnt));
    end

    // Control FSM plus the round-key store; outputs are all registered.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            last_rk <= '0;
            out     <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        out     <= {key_flat, rk1, 1152'b0};
                        last_rk <= rk1;
                        cnt     <= 4'd2;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int s = 2; s <= 10; s++) begin
                        if (cnt == 4'(s)) begin
                            out[1407-128*s -: 128] <= rk_next;
                        end
                    end
                    last_rk <= rk_next;
                    if (cnt == 4'd10) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_expansion.sv
// Testbench for key_expansion: known-answer vectors, random keys checked
// against an arithmetic model of the AES-128 key schedule, and hand-written
// sequences for reset, hold, restart and mid-run key changes.
module tb_key_expansion;

    logic           CLK;
    logic           RST;
    logic [0:127]   key;
    logic           enable;
    logic [1407:0]  out;
    logic           done;
    logic [1:0]     fsm_state;

    int total = 0;
    int bad   = 0;

    logic [7:0] sbox_m [256];

    typedef struct {
        logic [127:0] k;
        logic [127:0] rk1;
        logic [127:0] rk10;
        bit           chg;
    } vec_t;

    vec_t vecs [8];

    key_expansion dut (
        .CLK       (CLK),
        .RST       (RST),
        .key       (key),
        .enable    (enable),
        .out       (out),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // Clock generation
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int b = 0; b < 256; b++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] bb = 8'(b);
            for (int x = 1; x < 256; x++) begin
                if (b != 0 && gmul(bb, 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbox_m[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] model_expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [7:0]    rcon [11];
        logic [1407:0] r = '0;
        logic [31:0]   t;
        rcon[1] = 8'h01;
        for (int j = 2; j <= 10; j++) rcon[j] = gmul(rcon[j-1], 8'h02);
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rcon[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
        return r;
    endfunction

    function automatic logic [127:0] slot(input logic [1407:0] v, input int r);
        return v[1407-128*r -: 128];
    endfunction

    // ---------------- checkers ----------------
    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [1407:0] exp);
        for (int r = 0; r <= 10; r++)
            chk128($sformatf("%s.rk%0d", name, r), slot(out, r), slot(exp, r));
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Start from IDLE and run one whole expansion, checking every edge.
    task automatic run_exp(input string tag, input logic [127:0] k, input bit chg,
                           input logic [127:0] e_rk1, input logic [127:0] e_rk10);
        logic [1407:0] full = model_expand(k);
        logic [1407:0] part;
        key    = k;
        enable = 1'b1;
        tick();
        for (int n = 1; n <= 10; n++) begin
            part = '0;
            for (int r = 0; r <= n; r++) part[1407-128*r -: 128] = slot(full, r);
            chk_out($sformatf("%s.e%0d", tag, n), part);
            chk32($sformatf("%s.done%0d", tag, n), int'(done), (n == 10) ? 1 : 0);
            chk32($sformatf("%s.state%0d", tag, n), int'(fsm_state), (n == 10) ? 2 : 1);
            if (n == 1)  chk128({tag, ".kat_rk1"}, slot(out, 1), e_rk1);
            if (n == 10) chk128({tag, ".kat_rk10"}, slot(out, 10), e_rk10);
            if (chg && n == 2) key = {$urandom, $urandom, $urandom, $urandom};
            if (n < 10) tick();
        end
    endtask

    task automatic drop_enable();
        enable = 1'b0;
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [1407:0] snap;
        logic [1407:0] exp_full;
        logic [127:0]  rk;

        RST    = 1'b0;
        enable = 1'b1;
        key    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        build_sbox();

        // Reset held for two edges with enable high
        tick();
        tick();
        chk_out("reset", '0);
        chk32("reset.done", int'(done), 0);
        chk32("reset.state", int'(fsm_state), 0);

        RST    = 1'b1;
        enable = 1'b0;
        tick();
        chk32("idle.state", int'(fsm_state), 0);
        chk_out("idle.hold", '0);

        // Vector table: known answers, then random keys scored by the model
        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0};
        vecs[1] = '{128'h0,
                    128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b0};
        for (int i = 2; i < 8; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            exp_full = model_expand(rk);
            vecs[i] = '{rk, slot(exp_full, 1), slot(exp_full, 10), (i % 2 == 1)};
        end
        // Mid-run key change on a known-answer key too
        vecs[7].k    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vecs[7].rk1  = 128'ha0fafe1788542cb123a339392a6c7605;
        vecs[7].rk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        vecs[7].chg  = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_exp($sformatf("v%0d", i), vecs[i].k, vecs[i].chg, vecs[i].rk1, vecs[i].rk10);
            drop_enable();
            chk32($sformatf("v%0d.idle_done", i), int'(done), 0);
        end

        // Reset mid-run at edge 5, then restart
        key    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        enable = 1'b1;
        for (int n = 1; n <= 4; n++) tick();
        RST = 1'b0;
        tick();
        chk_out("midrst", '0);
        chk32("midrst.done", int'(done), 0);
        chk32("midrst.state", int'(fsm_state), 0);
        RST    = 1'b1;
        enable = 1'b0;
        tick();
        run_exp("restart", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Hold enable high in DONE: no auto-restart, out frozen
        key  = 128'h0;
        snap = model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk32($sformatf("hold.done%0d", c), int'(done), 1);
            chk32($sformatf("hold.state%0d", c), int'(fsm_state), 2);
        end
        chk_out("hold", snap);

        // Drop enable one cycle: done falls, schedule retained
        drop_enable();
        chk32("drop.done", int'(done), 0);
        chk32("drop.state", int'(fsm_state), 0);
        chk_out("drop", snap);

        run_exp("zero2", 128'h0, 1'b0,
                128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
